i3c_bit_engine: RTL and testbench
=================================

Name: i3c_bit_engine

Overview:
- Bit-level I3C/I2C bus engine: quarter-rate clock divider, bit-command modulator (SCL/SDA waveform per bus bit) and SDA pad driver with open-drain/push-pull selection.
- Sits below the byte/register sequencer: it consumes one bit command per bus bit, pulses a tick when ready for the next, and returns the sampled SDA level.

Parameters:
- MOD_BIT_CMD_WIDTH, 4, MSB index of the command word; i_cmd is MOD_BIT_CMD_WIDTH+1 bits wide.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd  in  MOD_BIT_CMD_WIDTH+1  bits [4:2] opcode, [1] reserved (ignore), [0] data bit.
- o_cmd_tick  out  1  one-i_clk pulse: current command finished, i_cmd sampled.
- o_clk_quarter  out  1  i_clk/4 square wave exported to the sequencer.
- o_scl  out  1  SCL level.
- o_sdo  out  1  live SDA level read back from the pad (to the sequencer).
- o_rx_bit  out  1  SDA value sampled during the last READ.
- o_push_pull_en  out  1  1 = SDA driven push-pull, 0 = open-drain.
- io_sda  inout  1  SDA pad.

Behaviour:
- Divider: 2-bit counter cnt increments every i_clk and wraps 3->0. o_clk_quarter = cnt[1] (period 4 clocks, 50 % duty). Internal q_tick is high in cycles where cnt==1, i.e. on the rising edge of o_clk_quarter.
- Opcodes:
  - 0 NOP.
  - 1 START.
  - 2 STOP.
  - 3 W_OD: write i_cmd[0], open-drain.
  - 4 W_PP: write i_cmd[0], push-pull.
  - 5 READ.
  - 6 SR: repeated start.
  - 7: treated as NOP.
- Each non-NOP command spans 4 phases (0..3). Phase advances on q_tick, so one bus bit = 16 i_clk.
- Per-phase waveforms:
  - START: scl 1,1,1,0; sda 1,1,0,0.
  - SR: scl 0,1,1,0; sda 1,1,0,0.
  - STOP: scl 0,1,1,1; sda 0,0,1,1.
  - W_OD / W_PP: scl 0,1,1,0; sda = bit in all phases.
  - READ: scl 0,1,1,0; sda released (1). o_rx_bit captures io_sda at the q_tick ending phase 2, i.e. while SCL is high.
- o_push_pull_en = 1 only for the whole of a W_PP command; 0 otherwise.
- Command handshake:
  - i_cmd is sampled on a q_tick when the engine is idle, or on the q_tick that ends phase 3.
  - o_cmd_tick pulses for exactly that one i_clk cycle at end of phase 3 of every non-NOP command.
  - A non-NOP sampled command starts at phase 0 immediately.
  - A NOP sampled command leaves the engine idle: outputs hold their last values and no tick is generated.
  - Back-to-back commands run with no gap cycles.
- i_cmd changes between q_ticks are ignored.
- PHY:
  - Push-pull: io_sda = sda.
  - Open-drain: io_sda = 0 when sda = 0, else high-Z (external pull-up).
  - o_sdo = io_sda, combinational.
- Reset values: cnt=0, o_clk_quarter=0, idle, phase=0, o_scl=1, internal sda=1 (bus released), o_push_pull_en=0, o_cmd_tick=0, o_rx_bit=1.
- Reset mid-command aborts on the next i_clk edge and returns to the reset state; no tick is issued.
- All outputs except o_sdo are registered.

Decomposition:
- Shared package: MOD_BIT_CMD_WIDTH, opcode constants, phase type (2 bits), the per-opcode SCL/SDA phase tables.
- One natural sub-module: i3c_sda_pad (tristate/open-drain driver plus readback). Divider and modulator stay in the top.

Test Plan:
- Reset held 3 cycles, then released. Required:
  - o_clk_quarter period 4 clocks.
  - o_scl=1, io_sda=Z (reads 1 with pull-up), o_cmd_tick=0.
- START then W_OD 0. Required:
  - SDA falls while SCL high.
  - o_cmd_tick pulses once per command, 16 clocks apart.
  - SDA driven 0 during W_OD phases 0-3.
- W_PP 1. Required:
  - o_push_pull_en=1 for 16 clocks.
  - io_sda driven strong 1.
  - o_push_pull_en returns to 0 on the next command.
- READ with an external driver forcing SDA=0 during SCL high. Required: o_rx_bit=0; with no external driver, o_rx_bit=1.
- STOP after a write. Required:
  - SDA rises while SCL high.
  - Bus ends with scl=1, sda released.
  - Subsequent NOP keeps the bus idle with no o_cmd_tick.
- Reset asserted in phase 2 of W_OD 0. Required: next clock o_scl=1, SDA released, no o_cmd_tick.

Source files
------------

// File: rtl/i3c_bit_engine_pkg.sv
// i3c_bit_engine_pkg: shared opcodes, phase type and per-opcode SCL/SDA phase tables
package i3c_bit_engine_pkg;
    localparam int MOD_BIT_CMD_WIDTH = 4;
    typedef enum logic [2:0] {
        OP_NOP, OP_START, OP_STOP, OP_W_OD, OP_W_PP, OP_READ, OP_SR, OP_RSVD
    } op_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    typedef logic [1:0] phase_t;
    localparam logic [3:0] SCL_START = 4'b0111;
    localparam logic [3:0] SCL_STOP  = 4'b1110;
    localparam logic [3:0] SCL_BIT   = 4'b0110;
    localparam logic [3:0] SDA_START = 4'b0011;
    localparam logic [3:0] SDA_STOP  = 4'b1100;
    localparam logic [3:0] SDA_REL   = 4'b1111;
    function automatic logic is_nop(op_t op);
        return op == OP_NOP || op == OP_RSVD;
    endfunction
    function automatic logic scl_of(op_t op, phase_t ph);
        logic [3:0] t;
        t = op == OP_START ? SCL_START : op == OP_STOP ? SCL_STOP : SCL_BIT;
        return t[ph];
    endfunction
    function automatic logic sda_of(op_t op, phase_t ph, logic b);
        logic [3:0] t;
        t = (op == OP_START || op == OP_SR) ? SDA_START :
            op == OP_STOP ? SDA_STOP :
            (op == OP_W_OD || op == OP_W_PP) ? {4{b}} : SDA_REL;
        return t[ph];
    endfunction
endpackage

// File: rtl/i3c_bit_engine_if.sv
// i3c_bit_engine_if: sequencer-facing bit command handshake and bus status
interface i3c_bit_engine_if;
    import i3c_bit_engine_pkg::*;
    logic [MOD_BIT_CMD_WIDTH:0] i_cmd;
    logic o_cmd_tick;
    logic o_clk_quarter;
    logic o_scl;
    logic o_sdo;
    logic o_rx_bit;
    logic o_push_pull_en;
    modport master (
        output i_cmd,
        input  o_cmd_tick, o_clk_quarter, o_scl, o_sdo, o_rx_bit, o_push_pull_en
    );
    modport slave (
        input  i_cmd,
        output o_cmd_tick, o_clk_quarter, o_scl, o_sdo, o_rx_bit, o_push_pull_en
    );
endinterface

// File: rtl/i3c_sda_pad.sv
// i3c_sda_pad: SDA driver, push-pull or open-drain, with live pad readback
module i3c_sda_pad (
    input  logic i_sda,
    input  logic i_pp,
    inout  wire  io_sda,
    output logic o_sdo
);
    assign io_sda = (i_pp || !i_sda) ? i_sda : 1'bz;
    assign o_sdo  = io_sda;
endmodule

// File: rtl/i3c_bit_engine.sv
// i3c_bit_engine: quarter-rate divider plus per-bit SCL/SDA modulator driving the SDA pad
module i3c_bit_engine
    import i3c_bit_engine_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    i3c_bit_engine_if.slave         bus,
    inout  wire                     io_sda
);
    logic [1:0] r_cnt;
    state_t     r_state, w_state_nx;
    op_t        r_op, w_op_nx;
    phase_t     r_phase, w_phase_nx;
    logic       r_bit, w_bit_nx;
    logic       r_scl, w_scl_nx;
    logic       r_sda, w_sda_nx;
    logic       r_pp, w_pp_nx;
    logic       r_rx, w_rx_nx;
    logic       r_tick, w_tick_nx;
    logic       w_sdo, w_q_tick, w_load, w_unused_rsvd;
    op_t        w_cmd_op;
    phase_t     w_phase_inc;

    assign w_unused_rsvd = bus.i_cmd[1];
    assign w_cmd_op      = op_t'(bus.i_cmd[MOD_BIT_CMD_WIDTH -: 3]);
    assign w_q_tick      = r_cnt == 2'd1;
    assign w_load        = w_q_tick && (r_state == ST_IDLE || r_phase == 2'd3);
    assign w_phase_inc   = r_phase + 2'd1;

    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_phase_nx = r_phase;
        w_bit_nx   = r_bit;
        w_scl_nx   = r_scl;
        w_sda_nx   = r_sda;
        w_pp_nx    = r_pp;
        w_tick_nx  = r_cnt == 2'd0 && r_state == ST_RUN && r_phase == 2'd3;
        w_rx_nx    = (w_q_tick && r_state == ST_RUN && r_op == OP_READ && r_phase == 2'd2) ? w_sdo : r_rx;
        if (w_load && is_nop(w_cmd_op)) begin
            w_state_nx = ST_IDLE;
            w_pp_nx    = 1'b0;
        end else if (w_load) begin
            w_state_nx = ST_RUN;
            w_op_nx    = w_cmd_op;
            w_bit_nx   = bus.i_cmd[0];
            w_phase_nx = 2'd0;
            w_scl_nx   = scl_of(w_cmd_op, 2'd0);
            w_sda_nx   = sda_of(w_cmd_op, 2'd0, bus.i_cmd[0]);
            w_pp_nx    = w_cmd_op == OP_W_PP;
        end else if (w_q_tick && r_state == ST_RUN) begin
            w_phase_nx = w_phase_inc;
            w_scl_nx   = scl_of(r_op, w_phase_inc);
            w_sda_nx   = sda_of(r_op, w_phase_inc, r_bit);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= 2'd0;
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_phase <= 2'd0;
            r_bit   <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_pp    <= 1'b0;
            r_rx    <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 2'd1;
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_phase <= w_phase_nx;
            r_bit   <= w_bit_nx;
            r_scl   <= w_scl_nx;
            r_sda   <= w_sda_nx;
            r_pp    <= w_pp_nx;
            r_rx    <= w_rx_nx;
            r_tick  <= w_tick_nx;
        end
    end

    i3c_sda_pad u_pad (
        .i_sda  (r_sda),
        .i_pp   (r_pp),
        .io_sda (io_sda),
        .o_sdo  (w_sdo)
    );

    assign bus.o_cmd_tick     = r_tick;
    assign bus.o_clk_quarter  = r_cnt[1];
    assign bus.o_scl          = r_scl;
    assign bus.o_sdo          = w_sdo;
    assign bus.o_rx_bit       = r_rx;
    assign bus.o_push_pull_en = r_pp;
endmodule

// File: tb/tb_i3c_bit_engine.sv
// tb_i3c_bit_engine: directed bit-command vectors with hand-computed SCL/SDA phase patterns
module tb_i3c_bit_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_low = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    wire  sda_w;

    i3c_bit_engine_if bus ();

    pullup (sda_w);
    assign sda_w = ext_low ? 1'b0 : 1'bz;

    i3c_bit_engine dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus),
        .io_sda  (sda_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // called in the sampling cycle (cnt==1); leaves the bench in the next sampling cycle
    task automatic send(input string tag, input logic [4:0] cmd, input logic [3:0] scl_e,
                        input logic [3:0] sda_e, input logic pp_e, input logic ext,
                        input logic rx_e, input logic tick_e);
        bus.i_cmd = cmd;
        @(negedge clk);
        ext_low = ext;
        #1;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) repeat (4) @(negedge clk);
            chk({tag, "_scl"}, 32'(bus.o_scl), 32'(scl_e[p]));
            chk({tag, "_sda"}, 32'(bus.o_sdo), 32'(sda_e[p]));
            chk({tag, "_pp"}, 32'(bus.o_push_pull_en), 32'(pp_e));
            chk({tag, "_notick"}, 32'(bus.o_cmd_tick), 32'd0);
        end
        chk({tag, "_rx"}, 32'(bus.o_rx_bit), 32'(rx_e));
        repeat (3) @(negedge clk);
        chk({tag, "_tick"}, 32'(bus.o_cmd_tick), 32'(tick_e));
        ext_low = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bus.i_cmd = 5'b00000;
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(bus.o_scl), 32'd1);
        chk("rst_sda", 32'(bus.o_sdo), 32'd1);
        chk("rst_tick", 32'(bus.o_cmd_tick), 32'd0);
        chk("rst_pp", 32'(bus.o_push_pull_en), 32'd0);
        chk("rst_rx", 32'(bus.o_rx_bit), 32'd1);
        chk("rst_cq", 32'(bus.o_clk_quarter), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("clkq", 32'(bus.o_clk_quarter), 32'((k % 4) >= 2));
            chk("idle_tick", 32'(bus.o_cmd_tick), 32'd0);
        end
        @(negedge clk);
        send("start", 5'b00100, 4'b0111, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1);
        send("wod0",  5'b01100, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        send("wpp1",  5'b10001, 4'b0110, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
        send("rd_lo", 5'b10100, 4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        send("rd_hi", 5'b10110, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
        send("sr",    5'b11000, 4'b0110, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1);
        send("wod1",  5'b01101, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
        send("stop",  5'b01000, 4'b1110, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b1);
        send("nop",   5'b00000, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        send("op7",   5'b11101, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.i_cmd = 5'b01100;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("abort_pre_scl", 32'(bus.o_scl), 32'd1);
        chk("abort_pre_sda", 32'(bus.o_sdo), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_scl", 32'(bus.o_scl), 32'd1);
        chk("abort_sda", 32'(bus.o_sdo), 32'd1);
        chk("abort_pp", 32'(bus.o_push_pull_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_tick", 32'(bus.o_cmd_tick), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
